// File: rtl/str_gen.sv
// str_gen: serial bit-string generator, shifts a handshaked pattern out MSB-first on one line.
// Optional even-parity bit after each frame when STR_GEN_PARITY_EN is defined.
module str_gen #(
    parameter int MAX_LEN    = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [MAX_LEN-1:0]        pat_data,
    input  logic [$clog2(MAX_LEN):0]  pat_len,
    input  logic                      pat_valid,
    output logic                      pat_ready,
    output logic                      out,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      done
);
    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);
`ifdef STR_GEN_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif
    localparam state_t POST = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t               state, state_n;
    logic [MAX_LEN-1:0]   sreg, sreg_n, aligned;
    logic [LW-1:0]        cnt, cnt_n, len;
    logic [3:0]           gcnt, gcnt_n;
    logic                 out_n, out_valid_n, done_n;
`ifdef STR_GEN_PARITY_EN
    logic                 par, par_n;
`endif

    assign pat_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // The pattern is left-aligned so the first bit to send is always at the MSB.
    always_comb begin
        len         = (pat_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : pat_len;
        aligned     = pat_data << (LW'(MAX_LEN) - len);
        state_n     = state;
        sreg_n      = sreg;
        cnt_n       = cnt;
        gcnt_n      = gcnt;
        out_n       = 1'b0;
        out_valid_n = 1'b0;
        done_n      = 1'b0;
`ifdef STR_GEN_PARITY_EN
        par_n       = par;
`endif
        case (state)
            IDLE: if (pat_valid) begin
                if (len == '0) begin
`ifdef STR_GEN_PARITY_EN
                    state_n     = PAR;
                    out_valid_n = 1'b1;
                    par_n       = 1'b0;
`else
                    state_n     = POST;
                    done_n      = 1'b1;
                    gcnt_n      = GAP_LAST;
`endif
                end else begin
                    state_n     = SHIFT;
                    out_n       = aligned[MAX_LEN-1];
                    out_valid_n = 1'b1;
                    sreg_n      = aligned << 1;
                    cnt_n       = len - LW'(1);
`ifdef STR_GEN_PARITY_EN
                    par_n       = aligned[MAX_LEN-1];
`endif
                end
            end
            SHIFT: if (cnt != '0) begin
                out_n       = sreg[MAX_LEN-1];
                out_valid_n = 1'b1;
                sreg_n      = sreg << 1;
                cnt_n       = cnt - LW'(1);
`ifdef STR_GEN_PARITY_EN
                par_n       = par ^ sreg[MAX_LEN-1];
`endif
            end else begin
`ifdef STR_GEN_PARITY_EN
                state_n     = PAR;
                out_n       = par;
                out_valid_n = 1'b1;
`else
                state_n     = POST;
                done_n      = 1'b1;
                gcnt_n      = GAP_LAST;
`endif
            end
`ifdef STR_GEN_PARITY_EN
            PAR: begin
                state_n = POST;
                done_n  = 1'b1;
                gcnt_n  = GAP_LAST;
            end
`endif
            GAP: begin
                state_n = (gcnt == '0) ? IDLE : GAP;
                gcnt_n  = gcnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            sreg      <= '0;
            cnt       <= '0;
            gcnt      <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
`ifdef STR_GEN_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            cnt       <= cnt_n;
            gcnt      <= gcnt_n;
            out       <= out_n;
            out_valid <= out_valid_n;
            done      <= done_n;
`ifdef STR_GEN_PARITY_EN
            par       <= par_n;
`endif
        end
    end
endmodule
